serial_comparator: RTL

- Bit-serial magnitude comparator. Accepts two unsigned WIDTH-bit operands one bit pair per accepted beat, MSB first.
- Produces the same one-hot result as the parallel 4-bit comparator: Y2 = A>B, Y1 = A=B, Y0 = A<B.
- Sits at the serial-link end of the datapath, where operands arrive over a 1-bit channel instead of a parallel bus.

---
 rtl/serial_comparator.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one-hot GT/EQ/LT result.
// Optional SERIAL_COMP_EARLY_EXIT_EN: finish on the first differing bit pair.
module serial_comparator #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic a_bit,
  input  logic b_bit,
  input  logic bit_valid,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic Y2,
  output logic Y1,
  output logic Y0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {REL_EQ = 2'd0, REL_GT = 2'd1, REL_LT = 2'd2} rel_t;

  // The first differing pair decides the relation; later pairs never override it.
  function automatic rel_t rel_step(input rel_t r, input logic a, input logic b);
    if (r == REL_EQ && a != b) return a ? REL_GT : REL_LT;
    return r;
  endfunction

  function automatic logic [2:0] rel_onehot(input rel_t r);
    case (r)
      REL_GT:  return 3'b100;
      REL_LT:  return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  state_t         state, state_nxt;
  rel_t           rel, rel_nxt, rel_upd;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           finish;
  logic           decided;
  logic [2:0]     result;

  assign bit_ready = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign rel_upd   = rel_step(rel, a_bit, b_bit);
  assign decided   = (rel == REL_EQ) && (a_bit != b_bit);
  assign {Y2, Y1, Y0} = result;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rel_nxt   = rel;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          rel_nxt   = REL_EQ;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          rel_nxt = rel_upd;
          cnt_nxt = cnt + CW'(1);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
          if (cnt == LAST || decided) begin
`else
          if (cnt == LAST) begin
`endif
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result register holds across new starts; only a finishing beat reloads it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rel    <= REL_EQ;
      done   <= 1'b0;
      result <= 3'b000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rel   <= rel_nxt;
      done  <= finish;
      if (finish) result <= rel_onehot(rel_upd);
    end
  end

`ifndef SERIAL_COMP_EARLY_EXIT_EN
  // Decision is only needed for the early-exit build.
  logic unused_decided;
  assign unused_decided = decided;
`endif

endmodule
